// File: rtl/ws2812b_decoder_if.sv
// Signal bundle between a WS2812B line source and the ws2812b_decoder receiver.
// The decoder uses the slave view; the line driver and observer use the master view.
interface ws2812b_decoder_if;
   logic        din;
   logic [23:0] data_out;
   logic        valid;
   logic        latch;
   logic        bit_err;
   logic        busy;
   logic        dout;

   modport master (
      output din,
      input  data_out, valid, latch, bit_err, busy, dout
   );

   modport slave (
      input  din,
      output data_out, valid, latch, bit_err, busy, dout
   );
endinterface

// File: rtl/ws2812b_decoder.sv
// WS2812B single-wire receiver: measures high pulses, assembles 24-bit GRB words MSB-first, detects latch gaps.
// Defining WS2812B_DECODER_FORWARD_EN enables chained-pixel mode (decode first word, forward the rest on dout).
module ws2812b_decoder #(
   parameter int BIT_THRESH   = 30,
   parameter int MIN_HIGH     = 8,
   parameter int MAX_HIGH     = 60,
   parameter int RESET_CYCLES = 2500
) (
   input  logic             scl,
   input  logic             reset_n,
   ws2812b_decoder_if.slave bus
);

   localparam int CW = $clog2(RESET_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW-1:0] THR_C   = CW'(BIT_THRESH);
   localparam logic [CW-1:0] MIN_C   = CW'(MIN_HIGH);
   localparam logic [CW-1:0] MAX_C   = CW'(MAX_HIGH);
   localparam logic [CW-1:0] GAP_C   = CW'(RESET_CYCLES);

`ifdef WS2812B_DECODER_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

   state_t        state_reg, state_next;
   logic          sync_reg, din_s_reg, din_q_reg;
   logic [CW-1:0] hi_cnt_reg, hi_cnt_next;
   logic [CW-1:0] lo_cnt_reg, lo_cnt_next;
   logic [4:0]    bit_cnt_reg, bit_cnt_next;
   logic [23:0]   shift_reg, shift_next;
   logic [23:0]   data_reg, data_next;
   logic          valid_reg, valid_next;
   logic          latch_reg, latch_next;
   logic          err_reg, err_next;
   logic          fwd_reg, fwd_next;
   logic          dout_reg, dout_next;

   logic          rise, fall, bit_val;
   logic [CW-1:0] hi_inc, lo_inc;
   logic [23:0]   word;

   assign rise    = din_s_reg & ~din_q_reg;
   assign fall    = ~din_s_reg & din_q_reg;
   assign bit_val = (hi_cnt_reg >= THR_C);
   assign word    = {shift_reg[22:0], bit_val};
   // Counters saturate so an arbitrarily long idle line can never wrap into a false match.
   assign hi_inc  = (hi_cnt_reg == CNT_MAX) ? hi_cnt_reg : hi_cnt_reg + ONE_C;
   assign lo_inc  = (lo_cnt_reg == CNT_MAX) ? lo_cnt_reg : lo_cnt_reg + ONE_C;

   always_ff @(posedge scl) begin
      if (!reset_n) begin
         sync_reg    <= 1'b0;
         din_s_reg   <= 1'b0;
         din_q_reg   <= 1'b0;
         state_reg   <= WAIT_GAP;
         hi_cnt_reg  <= '0;
         lo_cnt_reg  <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         data_reg    <= '0;
         valid_reg   <= 1'b0;
         latch_reg   <= 1'b0;
         err_reg     <= 1'b0;
         fwd_reg     <= 1'b0;
         dout_reg    <= 1'b0;
      end else begin
         sync_reg    <= bus.din;
         din_s_reg   <= sync_reg;
         din_q_reg   <= din_s_reg;
         state_reg   <= state_next;
         hi_cnt_reg  <= hi_cnt_next;
         lo_cnt_reg  <= lo_cnt_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         data_reg    <= data_next;
         valid_reg   <= valid_next;
         latch_reg   <= latch_next;
         err_reg     <= err_next;
         fwd_reg     <= fwd_next;
         dout_reg    <= dout_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      hi_cnt_next  = hi_cnt_reg;
      lo_cnt_next  = lo_cnt_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      data_next    = data_reg;
      valid_next   = 1'b0;
      latch_next   = 1'b0;
      err_next     = 1'b0;
      fwd_next     = fwd_reg;
      dout_next    = FWD && fwd_reg && din_s_reg;

      case (state_reg)
         WAIT_GAP: begin
            if (din_s_reg) lo_cnt_next = '0;
            else           lo_cnt_next = lo_inc;
            if (lo_cnt_reg == GAP_C) begin
               state_next = IDLE;
               fwd_next   = 1'b0;
            end
         end

         IDLE: begin
            fwd_next = 1'b0;
            if (rise) begin
               hi_cnt_next = ONE_C;
               state_next  = HIGH;
            end
         end

         HIGH: begin
            if (hi_cnt_reg > MAX_C) begin
               err_next     = 1'b1;
               bit_cnt_next = '0;
               lo_cnt_next  = '0;
               state_next   = WAIT_GAP;
            end else if (fall) begin
               if (hi_cnt_reg < MIN_C) begin
                  err_next     = 1'b1;
                  bit_cnt_next = '0;
                  lo_cnt_next  = '0;
                  state_next   = WAIT_GAP;
               end else begin
                  shift_next  = word;
                  lo_cnt_next = ONE_C;
                  state_next  = LOW;
                  if (bit_cnt_reg == 5'd23) begin
                     bit_cnt_next = '0;
                     // In chained mode only the first word of a frame is ours; later ones are forwarded.
                     if (!fwd_reg) begin
                        data_next  = word;
                        valid_next = 1'b1;
                     end
                     fwd_next = FWD;
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 5'd1;
                  end
               end
            end else if (din_s_reg) begin
               hi_cnt_next = hi_inc;
            end
         end

         LOW: begin
            if (lo_cnt_reg == GAP_C) begin
               latch_next = 1'b1;
               state_next = IDLE;
               fwd_next   = 1'b0;
               if (bit_cnt_reg != 5'd0) begin
                  err_next     = 1'b1;
                  bit_cnt_next = '0;
               end
            end else if (rise) begin
               hi_cnt_next = ONE_C;
               state_next  = HIGH;
            end else if (!din_s_reg) begin
               lo_cnt_next = lo_inc;
            end
         end

         default: state_next = WAIT_GAP;
      endcase
   end

   assign bus.data_out = data_reg;
   assign bus.valid    = valid_reg;
   assign bus.latch    = latch_reg;
   assign bus.bit_err  = err_reg;
   assign bus.busy     = (state_reg == HIGH) || (state_reg == LOW);
   assign bus.dout     = dout_reg;

endmodule
